// File: rtl/tela_pkg.sv
// Shared game-screen geometry and animator state encoding.
// Used by the victory-screen animator and the ship renderer.
package tela_pkg;

  localparam int H_VISIBLE    = 640;
  localparam int V_VISIBLE    = 480;
  localparam int SPRITE_CELLS = 11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTER = 2'd1;
  localparam logic [1:0] ST_HOVER = 2'd2;
  localparam logic [1:0] ST_LEAVE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ENTER = ST_ENTER,
    HOVER = ST_HOVER,
    LEAVE = ST_LEAVE
  } anim_state_e;

  typedef enum logic {
    BOB_UP   = 1'b0,
    BOB_DOWN = 1'b1
  } bob_dir_e;

  // Top-left coordinate that centres a square sprite of 'side' pixels in 'span'.
  function automatic int center_of(input int span, input int side);
    return (span - side) / 2;
  endfunction

endpackage

// File: rtl/vitoria_animador_if.sv
// Timing-in / position-out bundle between VGA timing, animator and renderer.
interface vitoria_animador_if;
  logic [9:0] h_counter;
  logic [9:0] v_counter;
  logic       start;
  logic       stop;
  logic [9:0] pos_X;
  logic [9:0] pos_Y;
  logic       active;
  logic       done;

  modport master (
    output h_counter, v_counter, start, stop,
    input  pos_X, pos_Y, active, done
  );

  modport slave (
    input  h_counter, v_counter, start, stop,
    output pos_X, pos_Y, active, done
  );
endinterface

// File: rtl/vitoria_animador_frame_tick.sv
// One-clk frame strobe at the first clk of (h=0, v=V_MATCH), independent of
// how many clks the pixel counters dwell on that position.
module frame_tick #(
  parameter logic [9:0] V_MATCH = 10'd480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  output logic       tick
);

  logic match;
  logic match_q;

  assign match = (h_counter == 10'd0) && (v_counter == V_MATCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) match_q <= 1'b0;
    else       match_q <= match;
  end

  assign tick = match && !match_q;

endmodule

// File: rtl/vitoria_animador.sv
// Victory-screen ship animator: slides the ship in from below, bobs it at
// screen centre, slides it back out on release. Moves only on frame ticks.
module vitoria_animador
  import tela_pkg::*;
#(
  parameter int SCALE     = 6,
  parameter int H_VISIBLE = tela_pkg::H_VISIBLE,
  parameter int V_VISIBLE = tela_pkg::V_VISIBLE,
  parameter int START_Y   = 480,
  parameter int STEP      = 8,
  parameter int BOB_AMP   = 4,
  parameter int BOB_DIV   = 4
) (
  input  logic               clk,
  input  logic               reset,
  vitoria_animador_if.slave  bus
);

  localparam int SIDE = SPRITE_CELLS * SCALE;
  localparam logic [9:0]  CENTER_X = 10'(center_of(H_VISIBLE, SIDE));
  localparam logic [9:0]  TARGET_Y = 10'(center_of(V_VISIBLE, SIDE));
  localparam logic [9:0]  START_Y10 = 10'(START_Y);
  localparam logic [10:0] TARGET11 = 11'(center_of(V_VISIBLE, SIDE));
  localparam logic [10:0] START11  = 11'(START_Y);
  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam int BW = (BOB_AMP > 0) ? $clog2(BOB_AMP + 1) : 1;
  localparam int DW = (BOB_DIV > 1) ? $clog2(BOB_DIV) : 1;
  localparam logic [BW-1:0] AMP_W  = BW'(BOB_AMP);
  localparam logic [DW-1:0] DIV_LAST = DW'(BOB_DIV - 1);

  anim_state_e   state_q, state_d;
  logic [9:0]    pos_y_q, pos_y_d;
  logic [BW-1:0] bob_off_q, bob_off_d, bob_nxt;
  bob_dir_e      bob_dir_q, bob_dir_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          tick;
  logic [10:0]   y_up, y_dn;

  frame_tick #(.V_MATCH(10'(V_VISIBLE))) u_tick (
    .clk       (clk),
    .reset     (reset),
    .h_counter (bus.h_counter),
    .v_counter (bus.v_counter),
    .tick      (tick)
  );

  // 11-bit so the saturation compares never see a wrapped value.
  assign y_up = {1'b0, pos_y_q} - STEP11;
  assign y_dn = {1'b0, pos_y_q} + STEP11;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pos_y_q   <= START_Y10;
      bob_off_q <= '0;
      bob_dir_q <= BOB_UP;
      div_cnt_q <= '0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_y_q   <= pos_y_d;
      bob_off_q <= bob_off_d;
      bob_dir_q <= bob_dir_d;
      div_cnt_q <= div_cnt_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_y_d   = pos_y_q;
    bob_off_d = bob_off_q;
    bob_dir_d = bob_dir_q;
    div_cnt_d = div_cnt_q;
    done_d    = 1'b0;
    bob_nxt   = bob_off_q;

    case (state_q)
      IDLE: begin
        pos_y_d = START_Y10;
        if (bus.start) state_d = ENTER;
      end

      ENTER: begin
        if (bus.stop) begin
          state_d = LEAVE;
        end else if (tick) begin
          if (y_up <= TARGET11) begin
            pos_y_d   = TARGET_Y;
            state_d   = HOVER;
            bob_off_d = '0;
            bob_dir_d = BOB_UP;
            div_cnt_d = '0;
          end else begin
            pos_y_d = y_up[9:0];
          end
        end
      end

      HOVER: begin
        if (bus.stop) begin
          state_d = LEAVE;
        end else if (tick) begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            // Triangle wave: reverse on reaching either end, no extra dwell.
            if (bob_dir_q == BOB_UP) begin
              bob_nxt = bob_off_q + 1'b1;
              if (bob_nxt == AMP_W) bob_dir_d = BOB_DOWN;
            end else begin
              bob_nxt = bob_off_q - 1'b1;
              if (bob_nxt == '0) bob_dir_d = BOB_UP;
            end
            bob_off_d = bob_nxt;
            pos_y_d   = TARGET_Y - 10'(bob_nxt);
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
      end

      LEAVE: begin
        if (tick) begin
          if (y_dn >= START11) begin
            pos_y_d = START_Y10;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            pos_y_d = y_dn[9:0];
          end
        end
      end

      default: state_d = IDLE;
    endcase

    active_d = (state_d != IDLE);
  end

  assign bus.pos_X  = CENTER_X;
  assign bus.pos_Y  = pos_y_q;
  assign bus.active = active_q;
  assign bus.done   = done_q;

endmodule
